// File: rtl/i2s_audio_rx.sv
// Purpose : I2S receiver; oversamples BCLK/LRCK/SDATA in clk, deserialises MSB-first slots.
// Latency : audio_valid ~3-4 clk after the BCLK pin rise carrying a slot's LSB.
// Backpr. : none; samples are presented with a one-clk strobe and must be taken that cycle.
//
// Ports:
//   clk, reset_n        system clock (>= 4x BCLK), asynchronous active-low reset
//   enable              receiver enable; low forces IDLE and clears the bit counter
//   i2s_bclk/lrck/sdata raw serial-audio pins, asynchronous to clk
//   audio_out           last completed sample of channel CH_SEL (0 = left, 1 = right)
//   audio_valid         one-clk pulse when audio_out updates
//   left_out/right_out  last completed sample of each channel
//   frame_err           one-clk pulse when a slot ended with fewer than DATA_W bits
module i2s_audio_rx #(
  parameter int DATA_W = 16,
  parameter bit CH_SEL = 1'b0,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_valid,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              frame_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  // Synchronisers: two flops each, plus a third bclk flop for edge detection.
  logic [2:0] bclk_pipe;
  logic [1:0] lrck_pipe;
  logic [1:0] sdata_pipe;

  logic              bclk_s, bclk_d, lrck_s, sdata_s;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              lr_last;

  logic              rise;
  logic              boundary;
  logic              cnt_lt;
  logic              slot_full;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt_inc;

  assign bclk_s  = bclk_pipe[1];
  assign bclk_d  = bclk_pipe[2];
  assign lrck_s  = lrck_pipe[1];
  assign sdata_s = sdata_pipe[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_pipe  <= '0;
      lrck_pipe  <= '0;
      sdata_pipe <= '0;
    end else begin
      bclk_pipe  <= {bclk_pipe[1:0], i2s_bclk};
      lrck_pipe  <= {lrck_pipe[0], i2s_lrck};
      sdata_pipe <= {sdata_pipe[0], i2s_sdata};
    end
  end

  always_comb begin
    rise      = bclk_s & ~bclk_d;
    boundary  = rise && (lrck_s != lr_last);
    cnt_lt    = (bit_cnt < CNT_W'(DATA_W));
    shift_nxt = {shift_reg[DATA_W-2:0], sdata_s};
    // Because of the 1-bit I2S delay, the boundary rise carries the previous
    // slot's LSB, so it is folded into the word when there is still room.
    word      = cnt_lt ? shift_nxt : shift_reg;
    // Bits seen including this rise reach DATA_W once bit_cnt >= DATA_W-1;
    // longer slots are complete too and simply keep their first DATA_W bits.
    slot_full = (bit_cnt >= CNT_W'(DATA_W - 1));
    cnt_inc   = (bit_cnt == '1) ? bit_cnt : bit_cnt + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_nxt = SYNC;
        SYNC:    if (boundary) state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Deserialiser and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      lr_last     <= 1'b0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      left_out    <= '0;
      right_out   <= '0;
      frame_err   <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!enable || state_q == IDLE) begin
        // While idle, follow LRCK so that SYNC only fires on a real channel
        // change seen after enabling, never on stale history.
        bit_cnt <= '0;
        lr_last <= lrck_s;
      end else if (rise) begin
        if (cnt_lt) shift_reg <= shift_nxt;
        if (boundary) begin
          bit_cnt <= '0;
          lr_last <= lrck_s;
          // The boundary that takes SYNC to RUN closes a slot we joined late.
          if (state_q == RUN) begin
            if (slot_full) begin
              if (lr_last) right_out <= word;
              else         left_out  <= word;
              if (lr_last == CH_SEL) begin
                audio_out   <= word;
                audio_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end else begin
          bit_cnt <= cnt_inc;
        end
      end
    end
  end

endmodule
